inst_fetch_resp: RTL and testbench

- Responder side of the instruction-fetch interface: accepts the PC/chip-enable pair driven by the fetch stage and returns the 32-bit instruction word after a configurable number of wait states.
- Holds the instruction memory array internally; a side-band load port writes it.
- Raises stallreq_o to CTRL while a fetch is outstanding, so the PC stays frozen until the word is delivered.
- Handles branch redirects mid-fetch and misaligned PCs.

---
 rtl/inst_fetch_resp.sv | 191 +++++++++++++++++++
 tb/tb_inst_fetch_resp.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: returns mem[pc] after WAIT_CYCLES wait states, stalls CTRL meanwhile.
// Optional one-entry refetch buffer enabled by defining IFETCH_BUF_EN.
module inst_fetch_resp #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        misalign_o,
  output logic        stallreq_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] mem_q [DEPTH];

  logic              same_addr;
  logic              accept;
  logic              rsp_load;
  logic [31:0]       rsp_addr;
  logic [ADDR_W-1:0] rsp_idx;
  logic [ADDR_W-1:0] load_idx;
  logic [31:0]       rd_word;
  logic              buf_hit;
  logic [31:0]       buf_rd;
  logic              unused_load_bits;

  assign same_addr  = (addr_i == req_addr_q);
  assign accept     = ce_i && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && !same_addr));
  assign stallreq_o = ce_i && !((state_q == ST_RESP) && same_addr);

  // With zero wait states the response is loaded on the accepting edge, from the incoming address
  assign rsp_addr = (state_q == ST_WAIT) ? req_addr_q : addr_i;
  assign rsp_idx  = rsp_addr[ADDR_W+1:2];
  assign load_idx = load_addr_i[ADDR_W+1:2];
  assign rd_word  = mem_q[rsp_idx];

  assign unused_load_bits = ^{load_addr_i[31:ADDR_W+2], load_addr_i[1:0]};

  // Memory array: no reset, read-before-write on a same-edge collision
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem_q[load_idx] <= load_data_i;
    end
  end

`ifdef IFETCH_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  assign buf_hit = buf_valid_q && (addr_i == buf_addr_q);
  assign buf_rd  = buf_inst_q;

  // Fill on aligned response loads; a write to the buffered index invalidates it (wins over a fill)
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_inst_d  = buf_inst_q;
    if (rsp_load && (rsp_addr[1:0] == 2'b00)) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = rsp_addr;
      buf_inst_d  = rd_word;
    end
    if (load_we_i && (buf_addr_d[ADDR_W+1:2] == load_idx)) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_inst_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_inst_q  <= buf_inst_d;
    end
  end
`else
  assign buf_hit = 1'b0;
  assign buf_rd  = '0;
`endif

  // Next-state and output computation
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    cnt_d        = cnt_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    misalign_d   = misalign_q;
    rsp_load     = 1'b0;

    if (!ce_i) begin
      state_d      = ST_IDLE;
      inst_d       = '0;
      inst_valid_d = 1'b0;
      misalign_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            req_addr_d = addr_i;
            if (buf_hit) begin
              state_d      = ST_RESP;
              inst_d       = buf_rd;
              inst_valid_d = 1'b1;
              misalign_d   = 1'b0;
            end else if (ZERO_WAIT) begin
              rsp_load = 1'b1;
            end else begin
              state_d      = ST_WAIT;
              cnt_d        = WAIT_LD;
              inst_d       = '0;
              inst_valid_d = 1'b0;
              misalign_d   = 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (!same_addr) begin
            req_addr_d = addr_i;
            cnt_d      = WAIT_LD;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              rsp_load = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (rsp_load) begin
      state_d      = ST_RESP;
      inst_valid_d = 1'b1;
      misalign_d   = (rsp_addr[1:0] != 2'b00);
      inst_d       = misalign_d ? 32'h0 : rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_addr_q   <= '0;
      cnt_q        <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      cnt_q        <= cnt_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: directed scenarios plus randomized fetch/load traffic
// checked against a transaction-level model (latency, data, misalign, buffer reuse).
module tb_inst_fetch_resp;

  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int          FULL_LAT    = WAIT_CYCLES + 1;
  localparam int          MAX_WAIT    = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] addr_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        misalign_o;
  logic        stallreq_o;
  logic        load_we_i;
  logic [31:0] load_addr_i;
  logic [31:0] load_data_i;

  inst_fetch_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .addr_i       (addr_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .misalign_o   (misalign_o),
    .stallreq_o   (stallreq_o),
    .load_we_i    (load_we_i),
    .load_addr_i  (load_addr_i),
    .load_data_i  (load_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mem_m [1 << ADDR_W];
  bit          in_resp;
  logic [31:0] last_addr;
  bit          buf_v;
  logic [31:0] buf_a;

  function automatic int unsigned idx_of(input logic [31:0] a);
    return 32'(a[ADDR_W+1:2]);
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce_i        = 1'b0;
    load_we_i   = 1'b1;
    load_addr_i = a;
    load_data_i = d;
    @(negedge clk);
    load_we_i = 1'b0;
    mem_m[idx_of(a)] = d;
    in_resp = 1'b0;
    if (buf_v && (idx_of(buf_a) == idx_of(a))) buf_v = 1'b0;
  endtask

  task automatic do_idle(input int n);
    @(negedge clk);
    ce_i = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    checks++;
    if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || misalign_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL idle outputs got v=%b i=%h m=%b s=%b want 0 0 0 0",
               inst_valid_o, inst_o, misalign_o, stallreq_o);
    end
    in_resp = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a, input string name);
    int          lat;
    int          exp_lat;
    bit          exp_mis;
    logic [31:0] exp_inst;
    exp_mis  = (a[1:0] != 2'b00);
    exp_inst = exp_mis ? 32'h0 : mem_m[idx_of(a)];
    if (in_resp && a == last_addr) exp_lat = 0;
    else begin
      exp_lat = FULL_LAT;
`ifdef IFETCH_BUF_EN
      if (buf_v && a == buf_a) exp_lat = 1;
`endif
    end
    @(negedge clk);
    ce_i   = 1'b1;
    addr_i = a;
    #1;
    lat = 0;
    while (stallreq_o === 1'b1 && lat < MAX_WAIT) begin
      if (lat > 0) begin
        checks++;
        if (inst_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL %s valid during wait cycle %0d got %b want 0", name, lat, inst_valid_o);
        end
      end
      @(negedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency addr=%h got %0d want %0d", name, a, lat, exp_lat);
    end
    checks++;
    if (inst_valid_o !== 1'b1 || inst_o !== exp_inst || misalign_o !== exp_mis) begin
      errors++;
      $display("FAIL %s response addr=%h got v=%b i=%h m=%b want v=1 i=%h m=%b",
               name, a, inst_valid_o, inst_o, misalign_o, exp_inst, exp_mis);
    end
    in_resp   = 1'b1;
    last_addr = a;
    if (!exp_mis) begin
      buf_v = 1'b1;
      buf_a = a;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce_i = 1'b0; addr_i = '0;
    load_we_i = 1'b0; load_addr_i = '0; load_data_i = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (inst_o !== 32'h0 || inst_valid_o !== 1'b0 || misalign_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs got i=%h v=%b m=%b s=%b want 0 0 0 0",
               inst_o, inst_valid_o, misalign_o, stallreq_o);
    end
    ce_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_ce got %b want 1", stallreq_o);
    end
    ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    in_resp = 1'b0;
    buf_v   = 1'b0;
  endtask

  task automatic test_preload();
    for (int i = 0; i < 32; i++) do_load(32'(i * 4), $urandom);
  endtask

  task automatic test_basic_latency();
    do_load(32'h0, 32'h3C01_0001);
    do_load(32'h4, 32'h3421_0002);
    do_fetch(32'h0, "basic_addr0");
    do_fetch(32'h4, "basic_addr4");
  endtask

  task automatic test_downstream_hold();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (stallreq_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_o !== mem_m[1]) begin
        errors++;
        $display("FAIL hold cycle %0d got s=%b v=%b i=%h want s=0 v=1 i=%h",
                 i, stallreq_o, inst_valid_o, inst_o, mem_m[1]);
      end
    end
  endtask

  task automatic test_redirect();
    int lat;
    do_load(32'h8, $urandom);
    do_load(32'h40, 32'hDEAD_BEEF);
    @(negedge clk);
    ce_i = 1'b1; addr_i = 32'h8;
    @(negedge clk);
    #1;
    addr_i = 32'h40;
    #1;
    lat = 0;
    while (stallreq_o === 1'b1 && lat < MAX_WAIT) begin
      checks++;
      if (inst_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL redirect stale response at cycle %0d got v=%b want 0", lat, inst_valid_o);
      end
      @(negedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != FULL_LAT || inst_o !== 32'hDEAD_BEEF || inst_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL redirect got lat=%0d i=%h v=%b want lat=%0d i=deadbeef v=1",
               lat, inst_o, inst_valid_o, FULL_LAT);
    end
    in_resp = 1'b1; last_addr = 32'h40; buf_v = 1'b1; buf_a = 32'h40;
  endtask

  task automatic test_misaligned();
    do_fetch(32'h6, "misaligned_6");
    do_fetch(32'h4B, "misaligned_4b");
  endtask

  task automatic test_alias();
    do_load(32'hABCD_0014, 32'h1357_9BDF);
    do_fetch(32'h1234_0014, "alias");
  endtask

  task automatic test_read_before_write();
    logic [31:0] old_d;
    logic [31:0] new_d;
    old_d = mem_m[20];
    new_d = ~old_d;
    do_idle(1);
    @(negedge clk);
    ce_i = 1'b1; addr_i = 32'h50;
    @(negedge clk);
    @(negedge clk);
    load_we_i = 1'b1; load_addr_i = 32'h50; load_data_i = new_d;
    @(negedge clk);
    load_we_i = 1'b0;
    #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_o !== old_d) begin
      errors++;
      $display("FAIL rbw collision got v=%b i=%h want v=1 i=%h", inst_valid_o, inst_o, old_d);
    end
    mem_m[20] = new_d;
    in_resp = 1'b1; last_addr = 32'h50;
    buf_v = 1'b0;
    do_idle(1);
    do_fetch(32'h50, "rbw_new_data");
  endtask

  task automatic test_reset_mid_fetch();
    do_idle(1);
    @(negedge clk);
    ce_i = 1'b1; addr_i = 32'h4;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || stallreq_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got v=%b i=%h s=%b want v=0 i=0 s=1", inst_valid_o, inst_o, stallreq_o);
    end
    ce_i = 1'b0;
    #1;
    checks++;
    if (stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall_ce0 got %b want 0", stallreq_o);
    end
    in_resp = 1'b0;
    buf_v   = 1'b0;
    do_fetch(32'h4, "after_reset_mem_kept");
  endtask

`ifdef IFETCH_BUF_EN
  task automatic test_buffer();
    do_idle(1);
    do_fetch(32'h0, "buf_first0");
    do_fetch(32'h4, "buf_first4");
    do_idle(1);
    do_fetch(32'h4, "buf_hit4");
    do_load(32'h4, 32'hCAFE_F00D);
    do_fetch(32'h4, "buf_invalidated");
  endtask
`endif

  task automatic test_random();
    logic [31:0] rv;
    logic [31:0] a;
    int          r;
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 9);
      rv = $urandom;
      a  = {rv[31:12], 5'b0, 5'($urandom_range(0, 31)), 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (r < 2) begin
        do_load(a, $urandom);
      end else if (r < 3) begin
        do_idle($urandom_range(1, 3));
      end else begin
        if (r == 9 && in_resp) a = last_addr;
        else if (r == 8 && buf_v) a = buf_a;
        do_fetch(a, "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic_latency();
    test_downstream_hold();
    test_redirect();
    test_misaligned();
    test_alias();
    test_read_before_write();
    test_reset_mid_fetch();
`ifdef IFETCH_BUF_EN
    test_buffer();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
